// File: rtl/kiss_seq_gen.sv
// kiss_seq_gen: transmit-side symbol generator for the 4-bit bbara-style
// command stream. Each accepted command emits cmd_count+1 copies of its
// symbol, separated by GAP idle cycles, then pulses done.
// Optional build macro KISS_GEN_TRACK_EN adds a shadow model of the 10-state
// downstream detector (track_state / track_out ports).
module kiss_seq_gen #(
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [3:0]       sym_out,
  output logic             sym_strobe,
  output logic             busy,
  output logic             done
`ifdef KISS_GEN_TRACK_EN
  ,
  output logic [3:0]       track_state,
  output logic [1:0]       track_out
`endif
);

  // Gap counter holds GAP-1 down to 0; keep at least one bit for GAP<=1.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [3:0] SYM_PAD  = 4'b0000;
  localparam logic [3:0] SYM_ADV  = 4'b0111;
  localparam logic [3:0] SYM_BACK = 4'b0011;
  localparam logic [3:0] SYM_JUMP = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic [GW-1:0]    gap_cnt_reg;

  function automatic logic [3:0] code_of(input logic [1:0] op);
    case (op)
      2'b01:   code_of = SYM_ADV;
      2'b10:   code_of = SYM_BACK;
      2'b11:   code_of = SYM_JUMP;
      default: code_of = SYM_PAD;
    endcase
  endfunction

  // Ready is the only unregistered output so a new command can be taken in
  // the same cycle done is high, giving back-to-back commands with no bubble.
  assign cmd_ready = (state_reg == S_IDLE);

  // Sequencer: state, repeat/gap counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      op_reg        <= 2'b00;
      remaining_reg <= '0;
      gap_cnt_reg   <= '0;
      sym_out       <= SYM_PAD;
      sym_strobe    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done       <= 1'b0;
          sym_out    <= SYM_PAD;
          sym_strobe <= 1'b0;
          busy       <= 1'b0;
          if (cmd_valid) begin
            op_reg        <= cmd_op;
            remaining_reg <= cmd_count;
            state_reg     <= S_EMIT;
            sym_out       <= code_of(cmd_op);
            sym_strobe    <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_EMIT: begin
          if (remaining_reg == '0) begin
            // Last symbol is on the bus now; no trailing gap.
            state_reg  <= S_IDLE;
            done       <= 1'b1;
            sym_out    <= SYM_PAD;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
          end else begin
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (GAP == 0) begin
              sym_out    <= code_of(op_reg);
              sym_strobe <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state_reg   <= S_GAP;
              gap_cnt_reg <= GW'(GAP - 1);
              sym_out     <= SYM_PAD;
              sym_strobe  <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg  <= S_EMIT;
            sym_out    <= code_of(op_reg);
            sym_strobe <= 1'b1;
            busy       <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          sym_out    <= SYM_PAD;
          sym_strobe <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef KISS_GEN_TRACK_EN
  // Detector state codes as seen on track_state.
  localparam logic [3:0] ST0 = 4'd0;
  localparam logic [3:0] ST1 = 4'd1;
  localparam logic [3:0] ST4 = 4'd2;
  localparam logic [3:0] ST2 = 4'd3;
  localparam logic [3:0] ST3 = 4'd4;
  localparam logic [3:0] ST7 = 4'd5;
  localparam logic [3:0] ST5 = 4'd6;
  localparam logic [3:0] ST6 = 4'd7;
  localparam logic [3:0] ST8 = 4'd8;
  localparam logic [3:0] ST9 = 4'd9;

  function automatic logic [3:0] track_next(input logic [3:0] s, input logic [3:0] sym);
    track_next = s;
    if (s > ST9) begin
      track_next = ST0;
    end else begin
      case (sym)
        SYM_ADV: begin
          case (s)
            ST0:     track_next = ST1;
            ST1:     track_next = ST2;
            ST2:     track_next = ST3;
            ST3:     track_next = ST3;
            default: track_next = ST1;
          endcase
        end
        SYM_BACK: begin
          case (s)
            ST2:      track_next = ST1;
            ST3, ST6: track_next = ST7;
            ST7:      track_next = ST8;
            ST8:      track_next = ST9;
            ST5:      track_next = ST4;
            default:  track_next = ST0;
          endcase
        end
        SYM_JUMP: begin
          case (s)
            ST4:     track_next = ST5;
            ST5:     track_next = ST6;
            ST6:     track_next = ST6;
            default: track_next = ST4;
          endcase
        end
        default: track_next = s;
      endcase
    end
  endfunction

  // Shadow detector advances on every strobed symbol the generator emits.
  always_ff @(posedge clock) begin
    if (reset) begin
      track_state <= ST0;
    end else if (sym_strobe) begin
      track_state <= track_next(track_state, sym_out);
    end else if (track_state > ST9) begin
      track_state <= ST0;
    end
  end

  // Predicted detector output depends on the symbol currently on the bus.
  always_comb begin
    track_out = 2'b00;
    if (track_state == ST3 && sym_out != SYM_BACK && sym_out != SYM_JUMP) begin
      track_out = 2'b10;
    end else if (track_state == ST6 && sym_out != SYM_BACK && sym_out != SYM_ADV) begin
      track_out = 2'b01;
    end
  end
`endif

endmodule

// File: tb/tb_kiss_seq_gen.sv
// Bench for kiss_seq_gen: three instances with GAP = 0, 1, 2 share one clock
// and reset. A per-instance queue of expected per-cycle outputs is built from
// each accepted command and compared every cycle on the falling edge.
module tb_kiss_seq_gen;

  typedef struct packed {
    logic [3:0] sym;
    logic       strobe;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  localparam exp_t IDLE_E = '{sym: 4'h0, strobe: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid  [3];
  logic       cmd_ready  [3];
  logic [1:0] cmd_op     [3];
  logic [3:0] cmd_count  [3];
  logic [3:0] sym_out    [3];
  logic       sym_strobe [3];
  logic       busy       [3];
  logic       done       [3];
`ifdef KISS_GEN_TRACK_EN
  logic [3:0] track_state [3];
  logic [1:0] track_out   [3];
  logic [3:0] adv_tab  [10] = '{4'd1, 4'd3, 4'd1, 4'd4, 4'd4, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
  logic [3:0] back_tab [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd5, 4'd8, 4'd2, 4'd5, 4'd9, 4'd0};
  logic [3:0] jump_tab [10] = '{4'd2, 4'd2, 4'd6, 4'd2, 4'd2, 4'd2, 4'd7, 4'd7, 4'd2, 4'd2};
  logic [3:0] mts [3];
`endif
  logic [3:0] code_tab [4] = '{4'h0, 4'h7, 4'h3, 4'hB};

  exp_t expq [3][$];
  logic rdy [3];
  int   strobe_cnt [3];
  int   done_cnt [3];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    kiss_seq_gen #(.CNT_W(4), .GAP(gi)) u_dut (
      .clock      (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid[gi]),
      .cmd_ready  (cmd_ready[gi]),
      .cmd_op     (cmd_op[gi]),
      .cmd_count  (cmd_count[gi]),
      .sym_out    (sym_out[gi]),
      .sym_strobe (sym_strobe[gi]),
      .busy       (busy[gi]),
      .done       (done[gi])
`ifdef KISS_GEN_TRACK_EN
      ,
      .track_state(track_state[gi]),
      .track_out  (track_out[gi])
`endif
    );
  end

`ifdef KISS_GEN_TRACK_EN
  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [3:0] sym);
    if (s > 4'd9) return 4'd0;
    if (sym == 4'h7) return adv_tab[s];
    if (sym == 4'h3) return back_tab[s];
    if (sym == 4'hB) return jump_tab[s];
    return s;
  endfunction

  function automatic logic [1:0] model_out(input logic [3:0] s, input logic [3:0] sym);
    if (s == 4'd4 && sym != 4'h3 && sym != 4'hB) return 2'b10;
    if (s == 4'd7 && sym != 4'h3 && sym != 4'h7) return 2'b01;
    return 2'b00;
  endfunction
`endif

  // One clock: compare every instance against its expected entry, advance models.
  task automatic cycle();
    exp_t cur;
    exp_t obs;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      cur = (expq[d].size() > 0) ? expq[d].pop_front() : IDLE_E;
      obs = {sym_out[d], sym_strobe[d], busy[d], done[d], cmd_ready[d]};
      checks++;
      assert (obs === cur) else begin
        errors++;
        $error("FAIL outputs gap=%0d cycle=%0d observed=%h expected=%h", d, cyc, obs, cur);
      end
`ifdef KISS_GEN_TRACK_EN
      checks++;
      assert (track_state[d] === mts[d]) else begin
        errors++;
        $error("FAIL track_state gap=%0d cycle=%0d observed=%0d expected=%0d", d, cyc, track_state[d], mts[d]);
      end
      checks++;
      assert (track_out[d] === model_out(mts[d], cur.sym)) else begin
        errors++;
        $error("FAIL track_out gap=%0d cycle=%0d observed=%b expected=%b", d, cyc, track_out[d], model_out(mts[d], cur.sym));
      end
      if (cur.strobe) mts[d] = model_next(mts[d], cur.sym);
`endif
      if (sym_strobe[d] === 1'b1) strobe_cnt[d]++;
      if (done[d] === 1'b1) done_cnt[d]++;
      rdy[d] = cur.ready;
      cmd_valid[d] = 1'b0;
    end
  endtask

  // Offer a command that the model says will be accepted at the next edge.
  task automatic drive(input int d, input logic [1:0] op, input logic [3:0] cnt);
    exp_t e;
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_count[d] = cnt;
    for (int k = 0; k <= int'(cnt); k++) begin
      e = {code_tab[op], 4'b1100};
      expq[d].push_back(e);
      if (k < int'(cnt))
        for (int g = 0; g < d; g++) expq[d].push_back({4'h0, 4'b0100});
    end
    expq[d].push_back({4'h0, 4'b0011});
    rdy[d] = 1'b0;
    $display("cmd gap=%0d op=%0d count=%0d cycle=%0d", d, op, cnt, cyc);
  endtask

  task automatic send(input int d, input logic [1:0] op, input logic [3:0] cnt);
    int n = 0;
    while (!rdy[d] && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    assert (cmd_ready[d] === 1'b1) else begin
      errors++;
      $error("FAIL ready_wait gap=%0d observed=%b expected=1", d, cmd_ready[d]);
    end
    drive(d, op, cnt);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (!rdy[d] && n < 200) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      expq[d].delete();
      cmd_valid[d] = 1'b0;
`ifdef KISS_GEN_TRACK_EN
      mts[d] = 4'd0;
`endif
    end
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int s0;
    int d0;
    logic [3:0] cnt;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_op[d] = 2'b00;
      cmd_count[d] = 4'h0;
      rdy[d] = 1'b1;
      strobe_cnt[d] = 0;
      done_cnt[d] = 0;
`ifdef KISS_GEN_TRACK_EN
      mts[d] = 4'd0;
`endif
    end
    // Reset state.
    cycle();
    reset = 1'b0;

    // Single ADV symbol: strobe at T+1, done/ready at T+2, quiet after.
    send(1, 2'b01, 4'd0);
    wait_idle(1);
    cycle();
    cycle();

    // GAP=2, BACK x3.
    send(2, 2'b10, 4'd2);
    wait_idle(2);

    // GAP=0, JUMP x4 then PAD taken in the done cycle.
    send(0, 2'b11, 4'd3);
    send(0, 2'b00, 4'd0);
    wait_idle(0);

    // Reset during the gap of a long ADV command, then a fresh command.
    send(2, 2'b01, 4'd5);
    cycle();
    cycle();
    cycle();
    do_reset();
    send(2, 2'b11, 4'd1);
    wait_idle(2);

    // Full-range count: 16 strobes, one done pulse.
    s0 = strobe_cnt[1];
    d0 = done_cnt[1];
    send(1, 2'b01, 4'd15);
    wait_idle(1);
    cycle();
    cycle();
    checks++;
    assert (strobe_cnt[1] - s0 == 16) else begin
      errors++;
      $error("FAIL max_count_strobes observed=%0d expected=16", strobe_cnt[1] - s0);
    end
    checks++;
    assert (done_cnt[1] - d0 == 1) else begin
      errors++;
      $error("FAIL max_count_done observed=%0d expected=1", done_cnt[1] - d0);
    end

    // Detector walk from a clean reset.
    do_reset();
    send(1, 2'b01, 4'd2);
    wait_idle(1);
`ifdef KISS_GEN_TRACK_EN
    checks++;
    assert (track_state[1] === 4'd4 && track_out[1] === 2'b10) else begin
      errors++;
      $error("FAIL walk_adv observed=%0d/%b expected=4/10", track_state[1], track_out[1]);
    end
`endif
    send(1, 2'b10, 4'd3);
    wait_idle(1);
`ifdef KISS_GEN_TRACK_EN
    checks++;
    assert (track_state[1] === 4'd0) else begin
      errors++;
      $error("FAIL walk_back observed=%0d expected=0", track_state[1]);
    end
`endif
    send(1, 2'b11, 4'd2);
    wait_idle(1);
`ifdef KISS_GEN_TRACK_EN
    checks++;
    assert (track_state[1] === 4'd7 && track_out[1] === 2'b01) else begin
      errors++;
      $error("FAIL walk_jump observed=%0d/%b expected=7/01", track_state[1], track_out[1]);
    end
`endif

    // Random traffic, including valid offered while busy and occasional resets.
    for (int i = 0; i < 800; i++) begin
      cycle();
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int d = 0; d < 3; d++) begin
        if (rdy[d]) begin
          if ($urandom_range(0, 2) != 0) begin
            cnt = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            drive(d, 2'($urandom_range(0, 3)), cnt);
          end
        end else if ($urandom_range(0, 1) == 1) begin
          cmd_valid[d] = 1'b1;
          cmd_op[d]    = 2'($urandom_range(0, 3));
          cmd_count[d] = 4'($urandom_range(0, 15));
        end
      end
    end
    for (int d = 0; d < 3; d++) wait_idle(d);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
